// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg
// Shared definitions for the execute-stage multiply/divide unit.
// The D-stage decoder, the hazard unit and the MDU all import this
// package, so the md_op encoding and the default latencies are kept in
// one place.
//   mdOp_e       : md_op encoding carried down the pipeline (4 bits)
//   MD_MULT_CYC  : default busy window after a mult/multu issue
//   MD_DIV_CYC   : default busy window after a div/divu issue
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } mdOp_e;

  localparam int MD_MULT_CYC = 5;
  localparam int MD_DIV_CYC  = 10;

endpackage

// File: rtl/e_mdu_calc.sv
// e_mdu_calc
// Purely combinational arithmetic core of the MDU. Produces the full
// {hi,lo} result for the four long operations in a single evaluation;
// the enclosing unit models the architectural latency with a counter.
//   i_op          : md operation (only MULT/MULTU/DIV/DIVU produce a result)
//   i_a           : rs operand
//   i_b           : rt operand
//   o_result      : {hi,lo} result, zero for non-arithmetic ops
//   o_divByZero   : high for DIV/DIVU with a zero divisor
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_divByZero
);

  logic [63:0]        w_sa;
  logic [63:0]        w_sb;
  logic [63:0]        w_ua;
  logic [63:0]        w_ub;
  logic [31:0]        w_divisor;
  logic signed [31:0] w_sQuo;
  logic signed [31:0] w_sRem;
  logic [31:0]        w_uQuo;
  logic [31:0]        w_uRem;
  logic               w_bZero;

  // Sign- and zero-extended operands; the low 64 bits of a 64x64
  // product of sign-extended values equal the signed 32x32 product.
  assign w_sa = {{32{i_a[31]}}, i_a};
  assign w_sb = {{32{i_b[31]}}, i_b};
  assign w_ua = {32'd0, i_a};
  assign w_ub = {32'd0, i_b};

  // The divider never sees zero so it stays free of X; the result is
  // discarded through o_divByZero anyway.
  assign w_bZero   = (i_b == 32'd0);
  assign w_divisor = w_bZero ? 32'd1 : i_b;

  // SystemVerilog signed division truncates toward zero and the
  // remainder takes the dividend's sign, matching MIPS div.
  assign w_sQuo = $signed(i_a) / $signed(w_divisor);
  assign w_sRem = $signed(i_a) % $signed(w_divisor);
  assign w_uQuo = i_a / w_divisor;
  assign w_uRem = i_a % w_divisor;

  // Select the result for the current op; everything else yields zero.
  always_comb begin
    o_result    = 64'd0;
    o_divByZero = 1'b0;
    case (i_op)
      MD_MULT:  o_result = w_sa * w_sb;
      MD_MULTU: o_result = w_ua * w_ub;
      MD_DIV: begin
        o_divByZero = w_bZero;
        o_result    = {w_sRem, w_sQuo};
      end
      MD_DIVU: begin
        o_divByZero = w_bZero;
        o_result    = {w_uRem, w_uQuo};
      end
      default: o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// e_mdu
// Execute-stage multiply/divide unit. Owns the architectural HI/LO
// registers and models a fixed-latency mult/div with a busy window the
// hazard unit uses to stall md instructions in D.
//   clk     : clock, all state updates on the rising edge
//   reset   : synchronous active-high reset
//   md_op   : md operation of the instruction in E
//   rs_val  : forwarded rs operand
//   rt_val  : forwarded rt operand
//   start   : a long operation issues at the next edge
//   busy    : long operation in progress
//   hi, lo  : current HI/LO registers
//   md_out  : mfhi/mflo read data toward the E/M register
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYC = MD_MULT_CYC,
  parameter int DIV_CYC  = MD_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_resHi;
  logic [31:0]      r_resLo;
  logic             r_pendWr;

  logic [63:0]      w_result;
  logic             w_divByZero;
  logic             w_isLong;
  logic             w_isMult;

  e_mdu_calc u_calc (
    .i_op        (md_op),
    .i_a         (rs_val),
    .i_b         (rt_val),
    .o_result    (w_result),
    .o_divByZero (w_divByZero)
  );

  assign w_isMult = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign w_isLong = w_isMult || (md_op == MD_DIV) || (md_op == MD_DIVU);

  assign busy  = (r_cnt != '0);
  assign start = w_isLong && !busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

  // mfhi/mflo read path; it always shows the committed HI/LO, so a read
  // during a busy window returns the stale values.
  always_comb begin
    md_out = 32'd0;
    case (md_op)
      MD_MFHI: md_out = r_hi;
      MD_MFLO: md_out = r_lo;
      default: md_out = 32'd0;
    endcase
  end

  // Counter and HI/LO state. While busy, every md_op is ignored and the
  // counter only runs down; the latched result is committed on the 1->0
  // step unless the issue was a divide by zero. When idle, a long op
  // latches its result and loads the counter, and mthi/mtlo write
  // directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_resHi  <= 32'd0;
      r_resLo  <= 32'd0;
      r_pendWr <= 1'b0;
    end else if (busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if ((r_cnt == CNT_W'(1)) && r_pendWr) begin
        r_hi     <= r_resHi;
        r_lo     <= r_resLo;
        r_pendWr <= 1'b0;
      end
    end else if (w_isLong) begin
      r_resHi  <= w_result[63:32];
      r_resLo  <= w_result[31:0];
      r_pendWr <= !w_divByZero;
      r_cnt    <= w_isMult ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
    end else if (md_op == MD_MTHI) begin
      r_hi <= rs_val;
    end else if (md_op == MD_MTLO) begin
      r_lo <= rs_val;
    end
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Execute-stage multiply/divide unit. It consumes the operands and decoded op that the ID/EX pipeline register presents in E, and owns the architectural HI/LO registers. It models fixed-latency mult/div with a busy window that the hazard unit uses to stall D-stage md instructions. mfhi/mflo read data leaves through md_out into the E/M pipeline register.

Parameters:
MULT_CYC, 5, cycles busy after a mult/multu issue (>=1)
DIV_CYC, 10, cycles busy after a div/divu issue (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
md_op  input  4  md operation of instruction currently in E (encoding in package)
rs_val  input  32  forwarded rs operand in E
rt_val  input  32  forwarded rt operand in E
start  output  1  combinational: md_op is MULT/MULTU/DIV/DIVU and busy==0
busy  output  1  registered: long operation in progress
hi  output  32  current HI register
lo  output  32  current LO register
md_out  output  32  combinational: hi when md_op==MFHI, lo when md_op==MFLO, else 0

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, cnt=0, pending results cleared, busy=0. Applies mid-operation: an in-flight op is discarded and HI/LO do not update.
- State: cnt (width fits max(MULT_CYC,DIV_CYC)), res_hi, res_lo, pend_wr (1 bit); busy = (cnt != 0).
- Issue edge (start==1): compute the result from rs_val/rt_val at this edge and latch it into res_hi/res_lo; cnt <= MULT_CYC or DIV_CYC.
  MULT: signed 64-bit product; res_hi=[63:32], res_lo=[31:0]. MULTU: unsigned.
  DIV: res_lo=signed quotient truncated toward zero, res_hi=remainder with the sign of the dividend. DIVU: unsigned.
  Divisor==0: pend_wr=0; the busy window still runs the full DIV_CYC; HI/LO stay unchanged. Otherwise pend_wr=1.
- Countdown: while cnt!=0, cnt decrements each edge. On the edge where cnt goes 1->0, hi/lo <= res_hi/res_lo if pend_wr.
- Timing: busy is high for exactly N cycles after the issue edge (N = MULT_CYC or DIV_CYC). New HI/LO are visible in the first cycle busy is low.
- MTHI/MTLO with busy==0: hi (or lo) <= rs_val at the next edge. The other register is untouched.
- Any md_op arriving while busy==1 is ignored: no issue, no mt write, md_out reflects the stale HI/LO. The hazard unit guarantees this never happens architecturally, and the bench checks it is harmless.
- An issue and a countdown completion cannot coincide, because start requires busy==0.
- md_op NONE or an undefined encoding: no state change; md_out=0.

Decomposition:
- Shared package e_mdu_pkg holds the md_op encoding constants (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8) and the default latencies MULT_CYC and DIV_CYC.
- The hazard unit and the D-stage decoder import the same package.
- One sub-module is natural: e_mdu_calc, purely combinational. It takes op, a, b and returns the 64-bit {hi,lo} result plus a div_by_zero flag. e_mdu keeps the counter and the HI/LO state.

Test Plan:
- MULT rs=0xFFFFFFFF rt=0x00000002 -> start=1 on the issue cycle; busy=1 for 5 cycles. Then hi=0xFFFFFFFF and lo=0xFFFFFFFE, with hi/lo unchanged until busy falls.
- MULTU with the same operands -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/2 -> lo=3, hi=1.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIVU rt=0 -> busy still lasts 10 cycles; afterwards hi=0x11, lo=0x22; MFHI gives md_out=0x11.
- MULT issued, then MTLO 0xABCD presented at cycle 2 of busy -> ignored, start=0. Final lo equals the product, not 0xABCD.
- DIV issued, reset asserted at busy cycle 4 -> next cycle busy=0, hi=lo=0. No late HI/LO write occurs in the following 10 cycles.
